systick_timer: RTL and testbench
================================

Name: systick_timer

Overview:
- Memory-mapped system tick timer. It is the request side of the CPU's systick interrupt path.
- It counts down a programmable reload value and raises a level interrupt request, do_systick_it, toward the CPU interrupt sequencer.
- The request holds until the sequencer acknowledges entry into the systick service sequence.
- Sits on the CPU peripheral register bus next to the interrupt sequencer. Tick counting is gated by the global enable_system.

Parameters:
- PRESCALE, 1: clock-enable divider. One timer tick every PRESCALE enabled cycles. Legal range 1..65535.
- RELOAD_W, 24: width of the RELOAD and CURRENT counters.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  reset, synchronous, active-high.
- enable_system  in  1  global run enable; when low, prescaler and counter freeze.
- reg_addr  in  2  register select: 0=CTRL, 1=RELOAD, 2=CURRENT, 3=reserved.
- reg_write  in  1  write strobe, one cycle.
- reg_read  in  1  read strobe, one cycle.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, registered.
- systick_ack  in  1  one-cycle pulse from the interrupt sequencer when it accepts the systick request (sequencer leaving IDLE for WAIT).
- do_systick_it  out  1  level interrupt request to the interrupt sequencer.

Behaviour:
- Reset values: do_systick_it=0, reg_rdata=0, CTRL=0, RELOAD=0, CURRENT=0, countflag=0, pending=0, prescaler=0.
- CTRL bit fields:
  - bit0 EN: counter run.
  - bit1 TICKINT: interrupt enable.
  - bit16 COUNTFLAG: read-only.
  - bit17 PENDCLR: write-1 clears pending; reads 0.
  - Other bits read 0.
- RELOAD: low RELOAD_W bits are read/write; upper bits read 0.
- CURRENT: reads the live counter. Any write clears CURRENT to 0 and clears COUNTFLAG; it does not change pending.
- Prescaler: increments each cycle with EN=1 and enable_system=1. When prescaler = PRESCALE-1 it asserts tick and wraps to 0. Clearing EN resets the prescaler to 0.
- Counter update on tick, in priority order:
  - CURRENT=0: load RELOAD; no event.
  - CURRENT=1: CURRENT<=0, COUNTFLAG<=1, pending<=1.
  - Otherwise: CURRENT<=CURRENT-1.
- Period: the event period is (RELOAD+1) ticks.
  - RELOAD=0 keeps CURRENT at 0 with no events.
  - A RELOAD write takes effect at the next reload only.
- Counter collision: a CPU write to CURRENT in the same cycle as a tick wins; the tick is discarded.
- Pending:
  - Set by a counter event.
  - Cleared by systick_ack or by a CTRL write with bit17=1.
  - Set and clear in the same cycle: set wins, so the request is never lost.
- do_systick_it: registered, equals pending AND TICKINT. Asserts the cycle after the 1->0 tick and drops the cycle after the acknowledge.
  - TICKINT=0 suppresses the request but pending is still recorded.
  - Setting TICKINT later raises the request immediately on the next edge.
- Reads: reg_rdata updates on the edge where reg_read=1, giving a 1-cycle read latency; it holds otherwise.
  - A CTRL read returns COUNTFLAG and clears it on the same edge, unless a counter event occurs in that edge, in which case the flag stays 1.
  - Reserved address reads 0; writes to it are ignored.
- Read/write same cycle: the read returns pre-write contents.
- Reset mid-count: everything returns to reset values in one cycle, including any outstanding request. The sequencer must tolerate do_systick_it dropping without an ack.

Test Plan:
- Basic period: PRESCALE=1, RELOAD=4, CTRL=0x3, enable_system=1 -> CURRENT reads 4,3,2,1,0; do_systick_it rises 1 cycle after CURRENT hits 0; the next event comes 5 ticks later.
- Acknowledge:
  - Request high; pulse systick_ack -> do_systick_it=0 the next cycle.
  - Ack in the same cycle as a new event -> do_systick_it stays 1.
- Masking and COUNTFLAG:
  - CTRL=0x1, RELOAD=2, run 3 ticks -> do_systick_it stays 0; CTRL read returns 0x0001_0001.
  - A second CTRL read returns 0x0000_0001.
  - Then write CTRL=0x3 -> do_systick_it=1 the next cycle.
- Freeze and write priority:
  - Drop enable_system for 10 cycles mid-count -> CURRENT is unchanged.
  - Write CURRENT on a tick cycle -> CURRENT=0 and COUNTFLAG=0.
  - Write CTRL=0x0002_0003 while pending -> request clears.
- Prescaler: PRESCALE=4, RELOAD=1 -> an event every 8 enabled cycles. Clearing EN, then setting it, restarts the prescale count from 0.
- Reset mid-operation: assert reset with the request high and CURRENT=3 -> next cycle all outputs are 0 and CURRENT reads 0. RELOAD reads 0 after reset.

Source files
------------

// File: rtl/systick_timer.sv
`timescale 1ns/1ps
// System tick timer: prescaled down-counter with a memory-mapped register
// interface and a level interrupt request toward the CPU interrupt sequencer.
module systick_timer #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned RELOAD_W = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_system,
  input  logic [1:0]  reg_addr,
  input  logic        reg_write,
  input  logic        reg_read,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic        systick_ack,
  output logic        do_systick_it
);

  localparam logic [1:0]          AddrCtrl    = 2'd0;
  localparam logic [1:0]          AddrReload  = 2'd1;
  localparam logic [1:0]          AddrCurrent = 2'd2;
  localparam logic [15:0]         PresLast    = 16'(PRESCALE - 1);
  localparam logic [RELOAD_W-1:0] CurOne      = RELOAD_W'(1);

  logic                en_q, en_d;
  logic                tickint_q, tickint_d;
  logic [RELOAD_W-1:0] reload_q, reload_d;
  logic [RELOAD_W-1:0] current_q, current_d;
  logic                countflag_q, countflag_d;
  logic                pending_q, pending_d;
  logic [15:0]         presc_q, presc_d;
  logic                irq_q, irq_d;
  logic [31:0]         rdata_q, rdata_d;

  logic tick;
  logic cnt_event;
  logic wr_ctrl, wr_reload, wr_current, rd_ctrl;
  logic unused_wdata;

  assign wr_ctrl    = reg_write && (reg_addr == AddrCtrl);
  assign wr_reload  = reg_write && (reg_addr == AddrReload);
  assign wr_current = reg_write && (reg_addr == AddrCurrent);
  assign rd_ctrl    = reg_read  && (reg_addr == AddrCtrl);

  // Only some write-data bits are architecturally meaningful.
  assign unused_wdata = ^reg_wdata;

  // Prescaler: held at zero while EN is clear, frozen while enable_system is low.
  always_comb begin
    tick    = 1'b0;
    presc_d = presc_q;
    if (!en_q) begin
      presc_d = '0;
    end else if (enable_system) begin
      if (presc_q == PresLast) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  // Down-counter; a CPU write to CURRENT discards a coincident tick.
  always_comb begin
    current_d = current_q;
    cnt_event = 1'b0;
    if (wr_current) begin
      current_d = '0;
    end else if (tick) begin
      if (current_q == '0) begin
        current_d = reload_q;
      end else if (current_q == CurOne) begin
        current_d = '0;
        cnt_event = 1'b1;
      end else begin
        current_d = current_q - CurOne;
      end
    end
  end

  // Control registers, flags and the interrupt request; event sets win over clears.
  always_comb begin
    en_d        = en_q;
    tickint_d   = tickint_q;
    reload_d    = reload_q;
    countflag_d = countflag_q;
    pending_d   = pending_q;

    if (wr_ctrl) begin
      en_d      = reg_wdata[0];
      tickint_d = reg_wdata[1];
    end
    if (wr_reload) begin
      reload_d = reg_wdata[RELOAD_W-1:0];
    end

    if (rd_ctrl || wr_current) countflag_d = 1'b0;
    if (cnt_event)             countflag_d = 1'b1;

    if (systick_ack || (wr_ctrl && reg_wdata[17])) pending_d = 1'b0;
    if (cnt_event)                                 pending_d = 1'b1;

    irq_d = pending_d & tickint_d;
  end

  // Registered read data; reflects contents before any same-cycle write.
  always_comb begin
    rdata_d = rdata_q;
    if (reg_read) begin
      case (reg_addr)
        AddrCtrl:    rdata_d = {15'b0, countflag_q, 14'b0, tickint_q, en_q};
        AddrReload:  rdata_d = 32'(reload_q);
        AddrCurrent: rdata_d = 32'(current_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_q        <= 1'b0;
      tickint_q   <= 1'b0;
      reload_q    <= '0;
      current_q   <= '0;
      countflag_q <= 1'b0;
      pending_q   <= 1'b0;
      presc_q     <= '0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      en_q        <= en_d;
      tickint_q   <= tickint_d;
      reload_q    <= reload_d;
      current_q   <= current_d;
      countflag_q <= countflag_d;
      pending_q   <= pending_d;
      presc_q     <= presc_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign reg_rdata     = rdata_q;
  assign do_systick_it = irq_q;

endmodule

// File: tb/tb_systick_timer.sv
`timescale 1ns/1ps
// Directed testbench for systick_timer: one instance with PRESCALE=1 and one
// with PRESCALE=4 share the bus stimulus; expectations are hand-computed.
module tb_systick_timer;

  logic        clock;
  logic        reset;
  logic        enable_system;
  logic [1:0]  reg_addr;
  logic        reg_write;
  logic        reg_read;
  logic [31:0] reg_wdata;
  logic        systick_ack;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4;

  int checks = 0;
  int errors = 0;

  systick_timer #(.PRESCALE(1), .RELOAD_W(24)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_system (enable_system),
    .reg_addr      (reg_addr),
    .reg_write     (reg_write),
    .reg_read      (reg_read),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (rdata1),
    .systick_ack   (systick_ack),
    .do_systick_it (irq1)
  );

  systick_timer #(.PRESCALE(4), .RELOAD_W(24)) dut4 (
    .clock         (clock),
    .reset         (reset),
    .enable_system (enable_system),
    .reg_addr      (reg_addr),
    .reg_write     (reg_write),
    .reg_read      (reg_read),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (rdata4),
    .systick_ack   (systick_ack),
    .do_systick_it (irq4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; outputs are sampled and inputs changed 1ns after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_write = 1'b1;
    cyc();
    reg_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d1, output logic [31:0] d4);
    reg_addr = a;
    reg_read = 1'b1;
    cyc();
    reg_read = 1'b0;
    d1 = rdata1;
    d4 = rdata4;
  endtask

  initial begin
    logic [31:0] v1, v4;
    reset         = 1'b1;
    enable_system = 1'b1;
    reg_addr      = 2'd0;
    reg_write     = 1'b0;
    reg_read      = 1'b0;
    reg_wdata     = 32'h0;
    systick_ack   = 1'b0;
    cyc();
    cyc();
    chk("rst_irq", 32'(irq1), 32'h0);
    chk("rst_rdata", rdata1, 32'h0);
    reset = 1'b0;
    rd(2'd0, v1, v4); chk("rst_ctrl", v1, 32'h0);
    rd(2'd1, v1, v4); chk("rst_reload", v1, 32'h0);
    rd(2'd2, v1, v4); chk("rst_current", v1, 32'h0);

    // Basic period, RELOAD=4: first tick loads 4, then counts down.
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h3);
    cyc();
    rd(2'd2, v1, v4); chk("cur_4", v1, 32'd4); chk("irq_idle", 32'(irq1), 32'h0);
    rd(2'd2, v1, v4); chk("cur_3", v1, 32'd3);
    rd(2'd2, v1, v4); chk("cur_2", v1, 32'd2); chk("irq_before_zero", 32'(irq1), 32'h0);
    // This edge takes CURRENT 1->0, so the request rises here.
    rd(2'd2, v1, v4); chk("cur_1", v1, 32'd1); chk("irq_at_zero", 32'(irq1), 32'h1);
    rd(2'd2, v1, v4); chk("cur_0", v1, 32'd0);

    // Acknowledge, then an ack coinciding with the next event 5 ticks later.
    systick_ack = 1'b1; cyc(); systick_ack = 1'b0;
    chk("ack_clears", 32'(irq1), 32'h0);
    cyc();
    cyc();
    chk("period_gap", 32'(irq1), 32'h0);
    systick_ack = 1'b1; cyc(); systick_ack = 1'b0;
    chk("ack_vs_event", 32'(irq1), 32'h1);
    wr(2'd0, 32'h0002_0003);
    chk("pendclr", 32'(irq1), 32'h0);

    // Masking and COUNTFLAG.
    reset = 1'b1; cyc(); reset = 1'b0;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    repeat (3) cyc();
    chk("masked_irq", 32'(irq1), 32'h0);
    rd(2'd0, v1, v4); chk("ctrl_countflag", v1, 32'h0001_0001);
    rd(2'd0, v1, v4); chk("ctrl_flag_cleared", v1, 32'h0000_0001);
    enable_system = 1'b0;
    wr(2'd0, 32'h3);
    chk("tickint_late", 32'(irq1), 32'h1);

    // Freeze with enable_system low.
    rd(2'd2, v1, v4); chk("freeze_before", v1, 32'd1);
    repeat (10) cyc();
    rd(2'd2, v1, v4); chk("freeze_after", v1, 32'd1);

    // Event sets COUNTFLAG, then a CURRENT write on a tick cycle wins.
    enable_system = 1'b1;
    cyc();
    cyc();
    wr(2'd2, 32'h55);
    rd(2'd2, v1, v4); chk("cur_write_wins", v1, 32'd0);
    rd(2'd0, v1, v4); chk("cur_write_clr_flag", v1, 32'h0000_0003);

    enable_system = 1'b0;
    wr(2'd0, 32'h0002_0003);
    chk("pendclr_frozen", 32'(irq1), 32'h0);
    rd(2'd0, v1, v4); chk("pendclr_reads0", v1, 32'h0000_0003);

    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v1, v4); chk("reserved", v1, 32'h0);

    // Read and write of RELOAD in the same cycle returns the old value.
    reg_addr  = 2'd1;
    reg_wdata = 32'd7;
    reg_write = 1'b1;
    reg_read  = 1'b1;
    cyc();
    reg_write = 1'b0;
    reg_read  = 1'b0;
    chk("rw_same_cycle", rdata1, 32'd2);
    rd(2'd1, v1, v4); chk("rw_new", v1, 32'd7);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, v1, v4); chk("reload_width", v1, 32'h00FF_FFFF);

    // Reset mid-operation with request high and CURRENT=3.
    reset = 1'b1; cyc(); reset = 1'b0;
    enable_system = 1'b1;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h3);
    repeat (9) cyc();
    chk("pre_reset_irq", 32'(irq1), 32'h1);
    enable_system = 1'b0;
    rd(2'd2, v1, v4); chk("pre_reset_cur", v1, 32'd3);
    reset = 1'b1;
    cyc();
    chk("reset_irq", 32'(irq1), 32'h0);
    chk("reset_rdata", rdata1, 32'h0);
    reset = 1'b0;
    enable_system = 1'b1;
    rd(2'd2, v1, v4); chk("reset_cur", v1, 32'h0);
    rd(2'd1, v1, v4); chk("reset_reload", v1, 32'h0);
    rd(2'd0, v1, v4); chk("reset_ctrl", v1, 32'h0);

    // PRESCALE=4, RELOAD=1: one event every 8 enabled cycles.
    reset = 1'b1; cyc(); reset = 1'b0;
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h3);
    repeat (7) cyc();
    chk("p4_pre_first", 32'(irq4), 32'h0);
    cyc();
    chk("p4_first_event", 32'(irq4), 32'h1);
    systick_ack = 1'b1; cyc(); systick_ack = 1'b0;
    chk("p4_ack", 32'(irq4), 32'h0);
    repeat (6) cyc();
    chk("p4_gap", 32'(irq4), 32'h0);
    cyc();
    chk("p4_second_event", 32'(irq4), 32'h1);

    // Clear EN two cycles into a prescale count, then re-enable: count restarts at 0.
    cyc();
    cyc();
    wr(2'd0, 32'h0002_0000);
    cyc();
    wr(2'd0, 32'h3);
    repeat (3) cyc();
    rd(2'd2, v1, v4); chk("p4_restart_a", v4, 32'd0);
    rd(2'd2, v1, v4); chk("p4_restart_b", v4, 32'd1);
    cyc();
    cyc();
    chk("p4_restart_quiet", 32'(irq4), 32'h0);
    cyc();
    chk("p4_restart_event", 32'(irq4), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
